ntt_addr_gen: RTL

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

---
 rtl/ntt_addr_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ntt_addr_gen.sv
// Butterfly address/twiddle sequencer for an in-place NTT: one request per butterfly, stage by stage.
// Define NTT_INTT_EN to add the inverse-order walk (inv input, tf_neg output).
module ntt_addr_gen #(
   parameter int LOG_N = 8,
   parameter int GAP   = 4,
   localparam int SW   = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef NTT_INTT_EN
   input  logic             inv,
   output logic             tf_neg,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic [LOG_N-1:0] addr_x,
   output logic [LOG_N-1:0] addr_y,
   output logic [LOG_N-1:0] tf_idx,
   output logic [SW-1:0]    stage,
   output logic             stage_last,
   output logic             busy,
   output logic             done
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LOG_N-2:0] b_q, b_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [GW-1:0]    gapCnt_q, gapCnt_d;
   logic             inv_q, inv_d;

   logic             handshake, bLast, stageFinal;
   logic [SW-1:0]    lenLog;
   logic [LOG_N-1:0] bExt, grp, lenVal, xVal, tfFwd, tfInv;

   assign handshake  = (state_q == S_RUN) && out_ready;
   assign bLast      = (b_q == '1);
   assign stageFinal = (stage_q == SW'(LOG_N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         b_q      <= '0;
         stage_q  <= '0;
         gapCnt_q <= '0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         b_q      <= b_d;
         stage_q  <= stage_d;
         gapCnt_q <= gapCnt_d;
         inv_q    <= inv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      b_d      = b_q;
      stage_d  = stage_q;
      gapCnt_d = gapCnt_q;
      inv_d    = inv_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               b_d     = '0;
               stage_d = '0;
`ifdef NTT_INTT_EN
               inv_d   = inv;
`endif
            end
         end
         S_RUN: begin
            if (handshake) begin
               if (bLast) begin
                  b_d = '0;
                  // The final stage keeps its stage number so DONE still reports it.
                  if (stageFinal) begin
                     state_d = S_DONE;
                  end else begin
                     stage_d  = stage_q + SW'(1);
                     gapCnt_d = '0;
                     if (GAP > 0) state_d = S_GAP;
                  end
               end else begin
                  b_d = b_q + (LOG_N-1)'(1);
               end
            end
         end
         S_GAP: begin
            if (gapCnt_q == GW'(GAP - 1)) state_d = S_RUN;
            else gapCnt_d = gapCnt_q + GW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Forward walk halves the butterfly span each stage; the inverse walk doubles it.
   always_comb begin
      lenLog = inv_q ? stage_q : (SW'(LOG_N - 1) - stage_q);
      bExt   = {1'b0, b_q};
      grp    = bExt >> lenLog;
      lenVal = LOG_N'(1) << lenLog;
      xVal   = ((grp << lenLog) << 1) | (bExt & (lenVal - LOG_N'(1)));
      tfFwd  = (LOG_N'(1) << stage_q) + grp;
      tfInv  = ({LOG_N{1'b1}} >> stage_q) - grp;
   end

   assign out_valid  = (state_q == S_RUN);
   assign addr_x     = out_valid ? xVal : '0;
   assign addr_y     = out_valid ? (xVal + lenVal) : '0;
   assign tf_idx     = out_valid ? (inv_q ? tfInv : tfFwd) : '0;
   assign stage      = stage_q;
   assign stage_last = out_valid && bLast;
   assign busy       = (state_q == S_RUN) || (state_q == S_GAP);
   assign done       = (state_q == S_DONE);
`ifdef NTT_INTT_EN
   assign tf_neg     = out_valid && inv_q;
`endif

endmodule
